// File: rtl/weighted_adder_tree.sv
// Weighted adder tree: per-channel power-of-two weighting, registered pairwise reduction,
// and an output stage that either passes each sum through or accumulates a window of sums.
module weighted_adder_tree #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned IN_W   = 4,
   parameter int unsigned SH_W   = 2,
   parameter int unsigned ACC_W  = 8,
   parameter int unsigned OUT_W  = 16
) (
   input  logic                     clk,
   input  logic                     clr_n,
   input  logic                     i_valid,
   input  logic [NUM_CH*IN_W-1:0]   i_data,
   input  logic                     cfg_load,
   input  logic [NUM_CH*SH_W-1:0]   cfg_shift,
   input  logic                     cfg_mode,
   input  logic [ACC_W-1:0]         cfg_acc_len,
   output logic                     o_valid,
   output logic [OUT_W-1:0]         o_result,
   output logic                     o_sat
);

   localparam int unsigned MAX_SH = (1 << SH_W) - 1;
   localparam int unsigned LOG_CH = $clog2(NUM_CH);
   localparam int unsigned SUM_W  = IN_W + MAX_SH + LOG_CH;

   // ------------------------------------------------------------------
   // Configuration
   // ------------------------------------------------------------------
   logic [NUM_CH*SH_W-1:0] shift_q;
   logic                   mode_q;
   logic [ACC_W-1:0]       acc_len_q;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         shift_q   <= '0;
         mode_q    <= 1'b0;
         acc_len_q <= ACC_W'(1);
      end else if (cfg_load) begin
         shift_q   <= cfg_shift;
         mode_q    <= cfg_mode;
         acc_len_q <= cfg_acc_len;
      end
   end

   // ------------------------------------------------------------------
   // Input stage: weight each channel with the shift held before this edge
   // ------------------------------------------------------------------
   logic [NUM_CH*SUM_W-1:0] in_d;
   logic [NUM_CH*SUM_W-1:0] in_q;
   logic                    in_vld_q;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_weight
      assign in_d[k*SUM_W +: SUM_W] =
         SUM_W'(i_data[k*IN_W +: IN_W]) << shift_q[k*SH_W +: SH_W];
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         in_q     <= '0;
         in_vld_q <= 1'b0;
      end else begin
         in_vld_q <= i_valid;
         if (i_valid) begin
            in_q <= in_d;
         end
      end
   end

   // ------------------------------------------------------------------
   // Registered pairwise reduction; level s holds NUM_CH >> (s+1) partial sums
   // ------------------------------------------------------------------
   for (genvar s = 0; s < LOG_CH; s++) begin : g_lvl
      localparam int unsigned CNT = NUM_CH >> (s + 1);

      logic [2*CNT*SUM_W-1:0] src;
      logic                   src_vld;
      logic [CNT*SUM_W-1:0]   sum_d;
      logic [CNT*SUM_W-1:0]   sum_q;
      logic                   vld_q;

      if (s == 0) begin : g_first
         assign src     = in_q;
         assign src_vld = in_vld_q;
      end else begin : g_next
         assign src     = g_lvl[s-1].sum_q;
         assign src_vld = g_lvl[s-1].vld_q;
      end

      for (genvar j = 0; j < CNT; j++) begin : g_add
         assign sum_d[j*SUM_W +: SUM_W] =
            src[2*j*SUM_W +: SUM_W] + src[(2*j+1)*SUM_W +: SUM_W];
      end

      always_ff @(posedge clk or negedge clr_n) begin
         if (!clr_n) begin
            sum_q <= '0;
            vld_q <= 1'b0;
         end else begin
            vld_q <= src_vld;
            if (src_vld) begin
               sum_q <= sum_d;
            end
         end
      end
   end

   logic [SUM_W-1:0] tree_sum;
   logic             tree_vld;

   assign tree_sum = g_lvl[LOG_CH-1].sum_q;
   assign tree_vld = g_lvl[LOG_CH-1].vld_q;

   // ------------------------------------------------------------------
   // Output stage: pass-through or windowed accumulation with saturation
   // ------------------------------------------------------------------
   logic [OUT_W:0]     acc_q;
   logic [OUT_W:0]     acc_d;
   logic [ACC_W-1:0]   cnt_q;
   logic [ACC_W-1:0]   cnt_d;
   logic [OUT_W:0]     total;
   logic [OUT_W-1:0]   clamped;
   logic               over;
   logic               last;
   logic               o_valid_d;
   logic [OUT_W-1:0]   o_result_d;
   logic               o_sat_d;

   always_comb begin
      // acc_q never exceeds 2^OUT_W-1, so the extra bit cannot wrap
      total      = acc_q + (OUT_W+1)'(tree_sum);
      over       = total[OUT_W];
      clamped    = over ? '1 : total[OUT_W-1:0];
      // acc_len 0 wraps to all ones, giving a 2^ACC_W window
      last       = (cnt_q == acc_len_q - ACC_W'(1));

      acc_d      = acc_q;
      cnt_d      = cnt_q;
      o_valid_d  = 1'b0;
      o_result_d = o_result;
      o_sat_d    = o_sat;

      if (cfg_load) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (tree_vld) begin
         if (!mode_q) begin
            o_valid_d  = 1'b1;
            o_result_d = OUT_W'(tree_sum);
            o_sat_d    = 1'b0;
         end else if (last) begin
            o_valid_d  = 1'b1;
            o_result_d = clamped;
            o_sat_d    = over;
            acc_d      = '0;
            cnt_d      = '0;
         end else begin
            acc_d = {1'b0, clamped};
            cnt_d = cnt_q + ACC_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         acc_q    <= '0;
         cnt_q    <= '0;
         o_valid  <= 1'b0;
         o_result <= '0;
         o_sat    <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         o_valid  <= o_valid_d;
         o_result <= o_result_d;
         o_sat    <= o_sat_d;
      end
   end

endmodule

// File: doc/weighted_adder_tree.md
WEIGHTED_ADDER_TREE -- requirements
Module: weighted_adder_tree

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of input channels (power of two, 2..16).
REQ-002 SHALL have parameter IN_W, default 4, meaning unsigned bits per channel.
REQ-003 SHALL have parameter SH_W, default 2, meaning per-channel shift-code width, with max shift MAX_SH = 2^SH_W-1.
REQ-004 SHALL have parameter ACC_W, default 8, meaning accumulate-length width.
REQ-005 SHALL have parameter OUT_W, default 16, meaning result width (>= SUM_W, where SUM_W = IN_W+MAX_SH+log2(NUM_CH)).
REQ-006 SHALL have port clk, input, width 1, meaning sole clock, rising edge.
REQ-007 SHALL have port clr_n, input, width 1, meaning asynchronous active-low reset.
REQ-008 SHALL have port i_valid, input, width 1, meaning sample strobe.
REQ-009 SHALL have port i_data, input, width NUM_CH*IN_W, meaning channel k at bits [k*IN_W +: IN_W].
REQ-010 SHALL have port cfg_load, input, width 1, meaning config capture strobe.
REQ-011 SHALL have port cfg_shift, input, width NUM_CH*SH_W, meaning channel k weight = 2^cfg_shift[k].
REQ-012 SHALL have port cfg_mode, input, width 1, meaning 0 = pass, 1 = accumulate.
REQ-013 SHALL have port cfg_acc_len, input, width ACC_W, meaning samples per accumulation (0 means 2^ACC_W).
REQ-014 SHALL have port o_valid, output, width 1, meaning result strobe, one cycle.
REQ-015 SHALL have port o_result, output, width OUT_W, meaning weighted sum, zero-extended.
REQ-016 SHALL have port o_sat, output, width 1, meaning current o_result is saturated.

Function
REQ-017 The block SHALL register config on a clk edge with cfg_load=1: shift codes, mode, and acc_len.
REQ-018 The input stage SHALL register each channel on an edge with i_valid=1 as i_data[k] << shift[k], zero-extended to SUM_W, using shift values held before that edge (a cfg_load on the same edge affects only later samples).
REQ-019 The tree SHALL add pairwise in log2(NUM_CH) stages, each registered, all widths SUM_W, with no overflow possible.
REQ-020 A valid bit SHALL travel alongside each stage, so that bubbles propagate and no data is dropped or duplicated.
REQ-021 Pass mode: a sample accepted at edge E SHALL give o_valid=1 and o_result = the tree sum after edge E+log2(NUM_CH)+1 (3 edges at defaults), at a throughput of 1 sample per cycle.
REQ-022 Accumulate mode: the accumulator (OUT_W+1 bits internally) and the counter SHALL add each tree result.
REQ-023 In accumulate mode, on the N-th result (N = acc_len), the block SHALL output accumulator+result, assert o_valid for one cycle, and clear both the accumulator and the counter on that same edge.
REQ-024 Saturation: if an accumulated total exceeds 2^OUT_W-1, o_result SHALL be 2^OUT_W-1 and o_sat=1 for that output; the accumulator SHALL hold at the saturated value until the window completes.
REQ-025 o_sat SHALL always be 0 in pass mode.
REQ-026 Edges without an output event SHALL leave o_valid=0 while o_result and o_sat hold their last values.
REQ-027 A cfg_load edge SHALL clear the accumulator and counter, discarding any partial window.
REQ-028 A tree result reaching the output stage on the same edge as cfg_load SHALL be discarded, with o_valid=0.
REQ-029 Results arriving after the cfg_load edge SHALL follow the new mode and acc_len.
REQ-030 Shift codes for samples already in flight SHALL be unaffected by cfg_load.
REQ-031 With acc_len=1, accumulate mode SHALL behave as pass mode, except that saturation is checked.

Reset
REQ-032 When clr_n=0, the block SHALL asynchronously clear all pipeline data and valid bits, accumulator, counter, o_valid, o_result, and o_sat to 0.
REQ-033 Reset values SHALL be all shift codes 0, mode 0, and acc_len 1.
REQ-034 Reset mid-operation SHALL discard all in-flight samples, and no o_valid SHALL appear from samples accepted before reset.
REQ-035 The first sample SHALL be accepted on the first clk rising edge after clr_n rises.

Verification
REQ-036 The bench SHALL cover this scenario: defaults, cfg shifts {1,0,1,0} (ch0..ch3), pass mode, one sample of all channels = 15 -> o_valid pulses once, exactly 3 edges later, with o_result=90 and o_sat=0.
REQ-037 The bench SHALL cover this scenario: pass mode, shifts 0, i_valid held high over 8 consecutive samples with ch0 = 1..8 and other channels 0 -> 8 consecutive o_valid with o_result 1..8 in order; then an i_valid gap of 2 cycles -> matching 2-cycle o_valid gap.
REQ-038 The bench SHALL cover this scenario: accumulate mode, acc_len=4, shifts 0, 4 samples of all channels = 1 -> a single o_valid with o_result=16; the next 4 samples yield 16 again (counter cleared).
REQ-039 The bench SHALL cover this scenario: accumulate mode, acc_len=0 (256), shifts all 3, all channels = 15 (tree sum 480) for 256 samples -> one o_valid with o_result=65535 and o_sat=1.
REQ-040 The bench SHALL cover this scenario: accumulate mode, acc_len=4, 2 samples of sum 4, then cfg_load (same config), then 4 samples of sum 4 -> exactly one o_valid, with o_result=16.
REQ-041 The bench SHALL cover this scenario: 2 samples in flight, clr_n pulsed low mid-pipeline -> all outputs 0 immediately and no o_valid afterwards; the first sample after release gives a correct result at 3-edge latency.
